// File: rtl/rv_fetch_queue_if.sv
// rv_fetch_queue_if: imem request/response, redirect and decode handshake bundle
interface rv_fetch_queue_if #(
  parameter int XLEN    = 32,
  parameter int MAX_OUT = 2
);
  logic                           imem_req_valid;
  logic                           imem_req_ready;
  logic [XLEN-1:0]                imem_req_addr;
  logic                           imem_rsp_valid;
  logic [31:0]                    imem_rsp_data;
  logic                           redirect_en;
  logic [XLEN-1:0]                redirect_pc;
  logic                           dec_valid;
  logic                           dec_ready;
  logic [31:0]                    dec_ins;
  logic [XLEN-1:0]                dec_pc;
  logic [$clog2(MAX_OUT+1)-1:0]   inflight;
  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_ins, dec_pc, inflight,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_en, redirect_pc, dec_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_ins, dec_pc, inflight,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_en, redirect_pc, dec_ready
  );
endinterface

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: sequential instruction fetch with outstanding requests, prefetch queue and redirect squash
module rv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4,
  parameter int              MAX_OUT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  rv_fetch_queue_if.master bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MAX_OUT + 1);
  logic [XLEN-1:0] fetch_pc, rsp_pc, redir_pc;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   q_count;
  logic [IW-1:0]   inflight, drop_cnt;
  logic [31:0]     ins_mem [QDEPTH];
  logic [XLEN-1:0] pc_mem  [QDEPTH];
  logic            fire, push, pop;
  always_comb begin
    redir_pc           = bus.redirect_pc & ~XLEN'(3);
    // squashed requests still hold a slot in inflight but never claim a queue entry
    bus.imem_req_valid = rst & ~bus.redirect_en & (int'(inflight) < MAX_OUT)
                       & (int'(q_count) + int'(inflight) - int'(drop_cnt) < QDEPTH);
    bus.imem_req_addr  = fetch_pc;
    fire               = bus.imem_req_valid & bus.imem_req_ready;
    push               = bus.imem_rsp_valid & ~bus.redirect_en & (drop_cnt == '0);
    bus.dec_valid      = rst & (q_count != '0);
    pop                = bus.dec_valid & bus.dec_ready & ~bus.redirect_en;
    bus.dec_ins        = rst ? ins_mem[rd_ptr] : '0;
    bus.dec_pc         = rst ? pc_mem[rd_ptr] : '0;
    bus.inflight       = inflight;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_count  <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + IW'(fire) - IW'(bus.imem_rsp_valid);
      if (bus.redirect_en) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        q_count  <= '0;
        drop_cnt <= inflight - IW'(bus.imem_rsp_valid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        q_count <= q_count + CW'(push) - CW'(pop);
        if (bus.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - IW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst && push) begin
      ins_mem[wr_ptr] <= bus.imem_rsp_data;
      pc_mem[wr_ptr]  <= rsp_pc;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && q_count == CW'(QDEPTH)));
endmodule
